// File: rtl/spi_init_seq.sv
// SD-card SPI initialisation sequencer: walks the dummy/CMD0/CMD8/ACMD41/
// CMD58/CMD59/boot-read sequence with R1 checking and bounded retries, and
// passes the microcontroller's command/status through when not initialising.
module spi_init_seq #(
    parameter int unsigned N_DUMMY     = 2,
    parameter int unsigned CMD_RETRY   = 3,
    parameter int unsigned ACMD41_MAX  = 1000,
    parameter logic [31:0] BOOT_ADDR   = 32'h00006020,
    parameter bit          MULTI_BLOCK = 1'b0,
    parameter logic [2:0]  CLKDIV_INIT = 3'b101,
    parameter logic [2:0]  CLKDIV_RUN  = 3'b001
) (
    input  logic        spi_clk_i,
    input  logic        spi_rst_i,
    input  logic        spi_init_i,
    input  logic        spi_restart_i,
    input  logic [47:0] spi_datamicro_i,
    input  logic [7:0]  spi_statusregmicro_i,
    input  logic [7:0]  spi_r1_i,
    input  logic [2:0]  spi_flagreg_i,
    output logic [47:0] spi_datainit_o,
    output logic [8:0]  spi_statusreginit_o,
    output logic        spi_initdone_o,
    output logic        spi_initerr_o,
    output logic [3:0]  spi_errcode_o,
    output logic        spi_initwritemem_o,
    output logic [15:0] spi_pollcnt_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41,
        S_CMD58, S_CMD59, S_BOOTRD, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] BOOT_OPC = MULTI_BLOCK ? 8'h52 : 8'h51;

    state_t      state_q, state_d, good_state;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic [15:0] pollcnt_q, pollcnt_d, poll_inc;
    logic [3:0]  errcode_q, errcode_d, bad_code;
    logic        opdone_q;
    logic        adv;
    logic        r1_ok;
    logic [47:0] seq_cmd;
    logic [8:0]  seq_status;
    logic        flags_unused;

    // WORD_COM and DATA_WR are not needed to sequence the card
    assign flags_unused = ^{spi_flagreg_i[2], spi_flagreg_i[0]};

    // one advance per rising edge of OPERT_DONE while the sequencer owns the engine
    assign adv      = spi_init_i & spi_flagreg_i[1] & ~opdone_q;
    assign poll_inc = pollcnt_q + 16'd1;

    // state and counter registers
    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            state_q   <= S_IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            pollcnt_q <= '0;
            errcode_q <= '0;
            opdone_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            pollcnt_q <= pollcnt_d;
            errcode_q <= errcode_d;
            opdone_q  <= spi_flagreg_i[1];
        end
    end

    // next-state: per-command R1 acceptance, retry/abort and ACMD41 polling
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        rcnt_d     = rcnt_q;
        pollcnt_d  = pollcnt_q;
        errcode_d  = errcode_q;
        r1_ok      = 1'b0;
        good_state = state_q;
        bad_code   = 4'd0;

        case (state_q)
            S_CMD0:   begin r1_ok = (spi_r1_i == 8'h01); good_state = S_CMD8;   bad_code = 4'd1; end
            S_CMD8:   begin r1_ok = (spi_r1_i == 8'h01); good_state = S_CMD55;  bad_code = 4'd2; end
            S_CMD55:  begin r1_ok = (spi_r1_i == 8'h01) || (spi_r1_i == 8'h00);
                            good_state = S_ACMD41; bad_code = 4'd4; end
            S_ACMD41: begin r1_ok = (spi_r1_i == 8'h00); good_state = S_CMD58;  bad_code = 4'd4; end
            S_CMD58:  begin r1_ok = (spi_r1_i == 8'h00); good_state = S_CMD59;  bad_code = 4'd5; end
            S_CMD59:  begin r1_ok = (spi_r1_i == 8'h00); good_state = S_BOOTRD; bad_code = 4'd6; end
            S_BOOTRD: begin r1_ok = (spi_r1_i == 8'h00); good_state = S_DONE;   bad_code = 4'd7; end
            default:  ;
        endcase

        if (spi_init_i) begin
            if (state_q == S_IDLE) begin
                state_d = S_DUMMY;
            end else if ((state_q == S_DONE || state_q == S_ERR) && spi_restart_i) begin
                state_d   = S_DUMMY;
                dcnt_d    = '0;
                rcnt_d    = '0;
                pollcnt_d = '0;
                errcode_d = '0;
            end else if (adv) begin
                if (state_q == S_DUMMY) begin
                    if (dcnt_q == 4'(N_DUMMY - 1)) begin
                        state_d = S_CMD0;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end else if (state_q == S_ACMD41 && spi_r1_i == 8'h01) begin
                    // card still busy: count the poll, then either time out or re-issue CMD55
                    pollcnt_d = poll_inc;
                    rcnt_d    = '0;
                    if (poll_inc == 16'(ACMD41_MAX)) begin
                        state_d   = S_ERR;
                        errcode_d = 4'd3;
                    end else begin
                        state_d = S_CMD55;
                    end
                end else if (r1_ok) begin
                    state_d = good_state;
                    rcnt_d  = '0;
                end else if (bad_code != 4'd0) begin
                    if (rcnt_q < 3'(CMD_RETRY)) begin
                        rcnt_d = rcnt_q + 3'd1;
                    end else begin
                        state_d   = S_ERR;
                        rcnt_d    = '0;
                        errcode_d = bad_code;
                    end
                end
            end
        end
    end

    // command and status words decoded from the registered state
    always_comb begin
        seq_cmd    = '1;
        seq_status = {CLKDIV_INIT, 6'b000101};
        case (state_q)
            S_IDLE, S_DUMMY, S_ERR: seq_status = {CLKDIV_INIT, 6'b000111};
            S_CMD0:   seq_cmd = 48'h400000000095;
            S_CMD8:   seq_cmd = 48'h48000001AA87;
            S_CMD55:  seq_cmd = 48'h770000000001;
            S_ACMD41: seq_cmd = 48'h694000000077;
            S_CMD58:  seq_cmd = 48'h7A0000000001;
            S_CMD59:  seq_cmd = 48'h7B00000000FF;
            S_BOOTRD: begin
                seq_cmd    = {BOOT_OPC, BOOT_ADDR, 8'hFF};
                seq_status = {CLKDIV_RUN, 6'b010101};
            end
            S_DONE:   seq_status = {CLKDIV_RUN, 6'b000101};
            default:  ;
        endcase
    end

    assign spi_datainit_o      = spi_init_i ? seq_cmd : spi_datamicro_i;
    assign spi_statusreginit_o = spi_init_i ? seq_status
                                            : {spi_statusregmicro_i[7:1], 1'b0, spi_statusregmicro_i[0]};
    assign spi_initdone_o      = (state_q == S_DONE);
    assign spi_initerr_o       = (state_q == S_ERR);
    assign spi_initwritemem_o  = (state_q == S_BOOTRD) || (state_q == S_DONE);
    assign spi_errcode_o       = errcode_q;
    assign spi_pollcnt_o       = pollcnt_q;

endmodule

// File: tb/tb_spi_init_seq.sv
// Bench for spi_init_seq: two instances (single-block/long poll budget and
// multi-block/short poll budget) share stimulus and are checked every cycle
// against a step-index model of the init sequence.
`timescale 1ns/1ps
module tb_spi_init_seq;

    // model step indices (position in the init sequence)
    localparam int P_IDLE = 0, P_DUMMY = 1, P_CMD0 = 2, P_CMD8 = 3, P_CMD55 = 4, P_ACMD41 = 5;
    localparam int P_CMD58 = 6, P_CMD59 = 7, P_BOOT = 8, P_DONE = 9, P_ERR = 10;
    localparam int N_DUMMY = 2, RETRY = 3;

    logic        clk = 1'b0;
    logic        rst, init, restart;
    logic [47:0] dmicro;
    logic [7:0]  smicro, r1;
    logic [2:0]  flag;
    logic [47:0] dout [2];
    logic [8:0]  sout [2];
    logic        done [2], err [2], wmem [2];
    logic [3:0]  code [2];
    logic [15:0] pcnt [2];

    int n_err = 0, n_chk = 0;
    bit chk_en = 0;

    int m_st [2]   = '{0, 0};
    int m_dum [2]  = '{0, 0};
    int m_try [2]  = '{0, 0};
    int m_poll [2] = '{0, 0};
    int m_code [2] = '{0, 0};
    bit m_opq = 0, m_adv;
    int MAXP [2] = '{1000, 4};
    bit MB [2]   = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    spi_init_seq #(.N_DUMMY(2), .CMD_RETRY(3), .ACMD41_MAX(1000), .BOOT_ADDR(32'h00006020),
                   .MULTI_BLOCK(1'b0), .CLKDIV_INIT(3'b101), .CLKDIV_RUN(3'b001)) u_dut0 (
        .spi_clk_i(clk), .spi_rst_i(rst), .spi_init_i(init), .spi_restart_i(restart),
        .spi_datamicro_i(dmicro), .spi_statusregmicro_i(smicro), .spi_r1_i(r1), .spi_flagreg_i(flag),
        .spi_datainit_o(dout[0]), .spi_statusreginit_o(sout[0]), .spi_initdone_o(done[0]),
        .spi_initerr_o(err[0]), .spi_errcode_o(code[0]), .spi_initwritemem_o(wmem[0]),
        .spi_pollcnt_o(pcnt[0]));

    spi_init_seq #(.N_DUMMY(2), .CMD_RETRY(3), .ACMD41_MAX(4), .BOOT_ADDR(32'h00006020),
                   .MULTI_BLOCK(1'b1), .CLKDIV_INIT(3'b101), .CLKDIV_RUN(3'b001)) u_dut1 (
        .spi_clk_i(clk), .spi_rst_i(rst), .spi_init_i(init), .spi_restart_i(restart),
        .spi_datamicro_i(dmicro), .spi_statusregmicro_i(smicro), .spi_r1_i(r1), .spi_flagreg_i(flag),
        .spi_datainit_o(dout[1]), .spi_statusreginit_o(sout[1]), .spi_initdone_o(done[1]),
        .spi_initerr_o(err[1]), .spi_errcode_o(code[1]), .spi_initwritemem_o(wmem[1]),
        .spi_pollcnt_o(pcnt[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int want_r1(input int s);
        case (s)
            P_CMD0, P_CMD8: return 1;
            default:        return 0;
        endcase
    endfunction

    function automatic int err_code(input int s);
        case (s)
            P_CMD0:            return 1;
            P_CMD8:            return 2;
            P_CMD55, P_ACMD41: return 4;
            P_CMD58:           return 5;
            P_CMD59:           return 6;
            default:           return 7;
        endcase
    endfunction

    // one advance of the sequence for instance i
    task automatic model_step(input int i, input bit a);
        int nxt;
        if (!init) return;
        if (m_st[i] == P_IDLE) begin
            m_st[i] = P_DUMMY;
        end else if ((m_st[i] == P_DONE || m_st[i] == P_ERR) && restart) begin
            m_st[i] = P_DUMMY; m_dum[i] = 0; m_try[i] = 0; m_poll[i] = 0; m_code[i] = 0;
        end else if (a && m_st[i] == P_DUMMY) begin
            m_dum[i]++;
            if (m_dum[i] == N_DUMMY) begin m_dum[i] = 0; m_st[i] = P_CMD0; end
        end else if (a && m_st[i] >= P_CMD0 && m_st[i] <= P_BOOT) begin
            nxt = -1;
            if (m_st[i] == P_CMD55) begin
                if (r1 <= 1) nxt = P_ACMD41;
            end else if (m_st[i] == P_ACMD41) begin
                if (r1 == 0) nxt = P_CMD58;
                else if (r1 == 1) begin
                    m_poll[i]++;
                    if (m_poll[i] == MAXP[i]) begin nxt = P_ERR; m_code[i] = 3; end
                    else nxt = P_CMD55;
                end
            end else if (int'(r1) == want_r1(m_st[i])) begin
                nxt = m_st[i] + 1;
            end
            if (nxt == -1) begin
                if (m_try[i] < RETRY) m_try[i]++;
                else begin m_code[i] = err_code(m_st[i]); m_st[i] = P_ERR; m_try[i] = 0; end
            end else begin
                m_st[i] = nxt; m_try[i] = 0;
            end
        end
    endtask

    function automatic logic [47:0] exp_cmd(input int i);
        if (!init) return dmicro;
        case (m_st[i])
            P_CMD0:   return 48'h400000000095;
            P_CMD8:   return 48'h48000001AA87;
            P_CMD55:  return 48'h770000000001;
            P_ACMD41: return 48'h694000000077;
            P_CMD58:  return 48'h7A0000000001;
            P_CMD59:  return 48'h7B00000000FF;
            P_BOOT:   return {(MB[i] ? 8'h52 : 8'h51), 32'h00006020, 8'hFF};
            default:  return 48'hFFFFFFFFFFFF;
        endcase
    endfunction

    function automatic logic [8:0] exp_stat(input int i);
        if (!init) return {smicro[7:1], 1'b0, smicro[0]};
        case (m_st[i])
            P_IDLE, P_DUMMY, P_ERR: return 9'b101000111;
            P_BOOT:                 return 9'b001010101;
            P_DONE:                 return 9'b001000101;
            default:                return 9'b101000101;
        endcase
    endfunction

    // reference model update
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = P_IDLE; m_dum[i] = 0; m_try[i] = 0; m_poll[i] = 0; m_code[i] = 0;
            end
            m_opq = 0;
        end else begin
            m_adv = init && flag[1] && !m_opq;
            m_opq = flag[1];
            for (int i = 0; i < 2; i++) model_step(i, m_adv);
        end
    end

    // per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d.cmd", i),  64'(dout[i]), 64'(exp_cmd(i)));
                chk($sformatf("d%0d.stat", i), 64'(sout[i]), 64'(exp_stat(i)));
                chk($sformatf("d%0d.done", i), 64'(done[i]), 64'(m_st[i] == P_DONE));
                chk($sformatf("d%0d.err", i),  64'(err[i]),  64'(m_st[i] == P_ERR));
                chk($sformatf("d%0d.wmem", i), 64'(wmem[i]), 64'(m_st[i] == P_BOOT || m_st[i] == P_DONE));
                chk($sformatf("d%0d.code", i), 64'(code[i]), 64'(m_code[i]));
                chk($sformatf("d%0d.poll", i), 64'(pcnt[i]), 64'(m_poll[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // one engine operation: OPERT_DONE high for 'hold' cycles carrying R1 on its rising cycle
    task automatic op(input logic [7:0] v, input int hold);
        r1 = v;
        flag[1] = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            r1 = 8'($urandom);
        end
        flag[1] = 1'b0;
        tick();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic happy();
        op(8'h00, 1); op(8'h00, 1);
        op(8'h01, 1); op(8'h01, 1); op(8'h01, 1); op(8'h00, 1);
        op(8'h00, 1); op(8'h00, 1); op(8'h00, 1);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] sm;
        int c;
        logic [7:0] v;
        rst = 1; init = 0; restart = 0; flag = '0; r1 = '0;
        dmicro = 48'hA5A50F0F1234; smicro = 8'hC3;
        repeat (3) tick();
        chk("rst.done", 64'(done[0]), 64'd0);
        chk("rst.err", 64'(err[0]), 64'd0);
        chk("rst.code", 64'(code[0]), 64'd0);
        chk("rst.poll", 64'(pcnt[0]), 64'd0);
        chk("rst.pass_cmd", 64'(dout[0]), 64'h0000A5A50F0F1234);
        chk("rst.pass_stat", 64'(sout[0]), 64'(9'b110000101));
        rst = 0;
        tick();
        chk_en = 1;

        // happy path
        init = 1;
        tick();
        chk("dummy.cmd", 64'(dout[0]), 64'h0000FFFFFFFFFFFF);
        chk("dummy.stat", 64'(sout[0]), 64'(9'b101000111));
        op(8'h00, 1); op(8'h00, 1);
        chk("cmd0.cmd", 64'(dout[0]), 64'h0000400000000095);
        chk("cmd0.stat", 64'(sout[0]), 64'(9'b101000101));
        op(8'h01, 1); op(8'h01, 1); op(8'h01, 1); op(8'h00, 1); op(8'h00, 1); op(8'h00, 1);
        chk("boot.cmd", 64'(dout[0]), 64'h00005100006020FF);
        chk("boot.stat", 64'(sout[0]), 64'(9'b001010101));
        chk("boot.wmem", 64'(wmem[0]), 64'd1);
        chk("boot.cmd_multi", 64'(dout[1]), 64'h00005200006020FF);
        op(8'h00, 1);
        chk("happy.done", 64'(done[0]), 64'd1);
        chk("happy.poll", 64'(pcnt[0]), 64'd0);
        chk("happy.code", 64'(code[0]), 64'd0);
        chk("happy.done1", 64'(done[1]), 64'd1);

        // ACMD41 polling; the short-budget instance times out at four polls
        do_restart();
        op(8'h00, 1); op(8'h00, 1); op(8'h01, 1); op(8'h01, 1);
        repeat (5) begin op(8'h01, 1); op(8'h01, 1); end
        chk("poll.err1", 64'(err[1]), 64'd1);
        chk("poll.code1", 64'(code[1]), 64'd3);
        chk("poll.cnt1", 64'(pcnt[1]), 64'd4);
        chk("poll.cnt0", 64'(pcnt[0]), 64'd5);
        op(8'h01, 1); op(8'h00, 1); op(8'h00, 1); op(8'h00, 1); op(8'h00, 1);
        chk("poll.done0", 64'(done[0]), 64'd1);
        chk("poll.cnt0_final", 64'(pcnt[0]), 64'd5);

        // CMD0 retries exhausted
        do_restart();
        chk("restart.code1", 64'(code[1]), 64'd0);
        op(8'h00, 1); op(8'h00, 1);
        repeat (3) op(8'hFF, 1);
        chk("retry.noerr", 64'(err[0]), 64'd0);
        chk("retry.cmd0", 64'(dout[0]), 64'h0000400000000095);
        op(8'hFF, 1);
        chk("retry.err", 64'(err[0]), 64'd1);
        chk("retry.code", 64'(code[0]), 64'd1);
        do_restart();
        chk("retry.code_clr", 64'(code[0]), 64'd0);
        happy();
        chk("retry.done", 64'(done[0]), 64'd1);

        // held OPERT_DONE counts once; passthrough freezes the sequence
        do_restart();
        op(8'h00, 1); op(8'h00, 1); op(8'h01, 1);
        op(8'h01, 10);
        chk("hold.cmd55", 64'(dout[0]), 64'h0000770000000001);
        init = 0;
        dmicro = 48'h123456789ABC;
        sm = 8'($urandom);
        smicro = sm;
        tick();
        chk("pass.cmd", 64'(dout[0]), 64'h0000123456789ABC);
        chk("pass.stat", 64'(sout[0]), 64'({sm[7:1], 1'b0, sm[0]}));
        op(8'h01, 1);
        init = 1;
        tick();
        chk("resume.cmd55", 64'(dout[0]), 64'h0000770000000001);
        op(8'h01, 1); op(8'h01, 1); op(8'h01, 1);
        chk("pre_rst.acmd41", 64'(dout[0]), 64'h0000694000000077);

        // asynchronous reset during ACMD41
        rst = 1;
        #1;
        chk("arst.poll", 64'(pcnt[0]), 64'd0);
        chk("arst.cmd", 64'(dout[0]), 64'h0000FFFFFFFFFFFF);
        chk("arst.stat", 64'(sout[0]), 64'(9'b101000111));
        chk("arst.wmem", 64'(wmem[0]), 64'd0);
        tick();
        rst = 0;
        tick();
        happy();
        chk("arst.done", 64'(done[0]), 64'd1);

        // randomized operation mix
        for (int k = 0; k < 600; k++) begin
            c = $urandom_range(0, 99);
            flag[0] = 1'($urandom);
            flag[2] = 1'($urandom);
            if (c < 5) begin
                init = 0;
                dmicro = {16'($urandom), 32'($urandom)};
                smicro = 8'($urandom);
                repeat ($urandom_range(1, 3)) tick();
                if ($urandom_range(0, 1) == 1) op(8'($urandom), 1);
                init = 1;
                tick();
            end else if (c < 9 || ((m_st[0] >= P_DONE || m_st[1] >= P_DONE) && c < 30)) begin
                do_restart();
            end else begin
                if (m_st[0] == P_ACMD41) v = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'h01;
                else v = 8'(want_r1(m_st[0]));
                if ($urandom_range(0, 9) == 0) v = 8'($urandom);
                if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 1));
                op(v, $urandom_range(1, 3));
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_init_seq.md
Name: spi_init_seq

Overview:
- Parametrised SD-card SPI initialisation sequencer with response checking.
- Drives command words and status-register words into the SPI microSD engine while initialisation is active; otherwise passes the microcontroller's command/status through.
- Adds over the first-generation init ROM:
  - per-command R1 checking with bounded retries;
  - bounded ACMD41 polling;
  - error reporting and restart;
  - selectable single/multi-block boot read;
  - separate init/run clock dividers.

Parameters:
N_DUMMY, 2, number of 48-bit all-ones dummy frames sent with CS high before CMD0 (1..15)
CMD_RETRY, 3, resends allowed per command on bad R1 before error (0..7)
ACMD41_MAX, 1000, max CMD55/ACMD41 poll pairs before timeout error (1..65535)
BOOT_ADDR, 32'h00006020, argument of the boot read command
MULTI_BLOCK, 0, 0: boot read is CMD17 (0x51); 1: CMD18 (0x52)
CLKDIV_INIT, 3'b101, status[8:6] during init commands
CLKDIV_RUN, 3'b001, status[8:6] for the boot read command

Ports:
spi_clk_i  in  1  clock
spi_rst_i  in  1  reset, asynchronous, active-high
spi_init_i  in  1  1: sequencer owns SPI engine; 0: passthrough and sequencer frozen
spi_restart_i  in  1  single-cycle pulse; from DONE or ERR, restarts at DUMMY
spi_datamicro_i  in  48  microcontroller command (passthrough)
spi_statusregmicro_i  in  8  microcontroller status (passthrough)
spi_r1_i  in  8  R1 response, valid in the cycle OPERT_DONE rises
spi_flagreg_i  in  3  [0] WORD_COM, [1] OPERT_DONE, [2] DATA_WR
spi_datainit_o  out  48  command to SPI engine
spi_statusreginit_o  out  9  status word to SPI engine
spi_initdone_o  out  1  sequence completed successfully
spi_initerr_o  out  1  sequence aborted
spi_errcode_o  out  4  abort cause
spi_initwritemem_o  out  1  boot-read data path to memory enabled
spi_pollcnt_o  out  16  ACMD41 polls performed

Behaviour:
- Status word layout:
  - [8:6] clock divider; [5] 0; [4] microSD read; [3] microSD write; [2] MSB-first; [1] init-SS (CS held high); [0] spi_operation.
- Output muxing:
  - spi_init_i=0: spi_datainit_o = spi_datamicro_i; spi_statusreginit_o = {statusmicro[7:1],1'b0,statusmicro[0]}.
  - spi_init_i=1: both outputs are a combinational decode of the registered state.
- Advance event:
  - adv = spi_init_i & OPERT_DONE & ~opdone_q, a rising-edge detect on spi_flagreg_i[1] (opdone_q is a register).
  - A level held high counts once.
  - Every state transition and counter update happens on the clock edge where adv=1 and uses spi_r1_i from that cycle.
  - spi_init_i low freezes state and all counters; the sequence resumes when it returns high.
- States, each with command, status word and transition on adv:
  - IDLE: leaves to DUMMY on the first cycle spi_init_i=1, with no adv needed. Outputs as for DUMMY.
  - DUMMY: 48'hFFFFFFFFFFFF, {CLKDIV_INIT,6'b000111}. dcnt increments; goes to CMD0 when dcnt=N_DUMMY-1.
  - CMD0: 48'h400000000095, {CLKDIV_INIT,6'b000101}. Expects R1=8'h01.
  - CMD8: 48'h48000001AA87, same status. Expects R1=8'h01.
  - CMD55: 48'h770000000001, same status. Expects R1 of 8'h01 or 8'h00.
  - ACMD41: 48'h694000000077, same status.
    - R1=8'h00: go to CMD58.
    - R1=8'h01: pollcnt+1; if the new value equals ACMD41_MAX go to ERR with code 3, else go to CMD55.
    - Any other R1 is a bad response.
  - CMD58: 48'h7A0000000001. Expects R1=8'h00.
  - CMD59: 48'h7B00000000FF. Expects R1=8'h00.
  - BOOTRD: {MULTI_BLOCK?8'h52:8'h51, BOOT_ADDR, 8'hFF}, {CLKDIV_RUN,6'b010101}. spi_initwritemem_o=1. Expects R1=8'h00; on success goes to DONE.
  - DONE: spi_initdone_o=1, spi_initwritemem_o=1. Command output is all-ones; status is {CLKDIV_RUN,6'b000101}.
  - ERR: spi_initerr_o=1. Command output is all-ones; status is {CLKDIV_INIT,6'b000111}, so CS is held high.
- Retry rule:
  - A bad R1 with rcnt<CMD_RETRY sets rcnt+1 and the state repeats.
  - Otherwise go to ERR.
  - rcnt clears on every state change.
  - CMD_RETRY=0 means the first bad R1 errors.
- Error codes: 0 none, 1 CMD0, 2 CMD8, 3 ACMD41 timeout, 4 CMD55/ACMD41 bad R1, 5 CMD58, 6 CMD59, 7 boot read.
- spi_errcode_o is held until restart or reset.
- spi_restart_i:
  - Accepted in DONE or ERR when spi_init_i=1.
  - Goes to DUMMY; clears errcode, pollcnt, rcnt and dcnt.
  - Ignored in all other states.
- Simultaneous adv and restart in DONE/ERR: restart wins.
- Reset:
  - State IDLE; all counters 0.
  - spi_initdone_o=0, spi_initerr_o=0, spi_initwritemem_o=0, spi_errcode_o=0, spi_pollcnt_o=0.
  - Data/status outputs follow the mux rule with the IDLE decode.
  - Reset mid-operation aborts immediately.
- Latency: one adv edge per state transition; no combinational path from spi_r1_i to outputs.

Test Plan:
- Happy path, N_DUMMY=2: R1 sequence 01,01,01,00,00,00,00 with the ACMD41 R1=00 on its first attempt -> states walk through BOOTRD with command 48'h5100006020FF and status 9'b001010101. After the final adv, spi_initdone_o=1, spi_pollcnt_o=0 and spi_errcode_o=0.
- ACMD41 polling: ACMD41 returns 01 five times, then 00 -> CMD55/ACMD41 alternate five times, spi_pollcnt_o=5, sequence completes. With ACMD41_MAX=4 and 01 returned forever -> ERR with code 3 and pollcnt=4.
- Retry/error: CMD0 returns 8'hFF four times with CMD_RETRY=3 -> CMD0 is resent 3 times, then spi_initerr_o=1 and code 1. spi_restart_i then -> DUMMY, code 0, full sequence succeeds.
- OPERT_DONE held high 10 cycles in CMD8 -> exactly one advance. Dropping spi_init_i mid-CMD55 -> outputs pass through 48'h123456789ABC and status {st[7:1],0,st[0]}, and state is unchanged on return.
- MULTI_BLOCK=1 -> boot command 48'h5200006020FF. Asserting spi_rst_i during ACMD41 -> all outputs at reset values asynchronously, and the sequence restarts from IDLE.
